// File: rtl/activation_unit.sv
// Two-stage pipelined activation for LANES fixed-point lanes.
// Ports: clk/rst, mode/threshold, cnt_clr, in_* / out_* handshake, zero_cnt.
module activation_unit #(
  parameter int WIDTH      = 16,
  parameter int FRAC       = 8,
  parameter int LANES      = 4,
  parameter int LEAK_SHIFT = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       threshold,
  input  logic                   cnt_clr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [15:0]            zero_cnt
);

  localparam int LW  = LANES * WIDTH;
  localparam int NZW = $clog2(LANES + 1);

  logic             s1_valid;
  logic [LW-1:0]    s1_data;
  logic [1:0]       s1_mode;
  logic [WIDTH-1:0] s1_thr;

  logic             s2_valid;
  logic [LW-1:0]    s2_data;

  logic             adv1;
  logic             adv2;
  logic             accept;
  logic             out_fire;
  logic [LW-1:0]    act_data;
  logic [NZW-1:0]   nz;
  logic [16:0]      cnt_sum;
  logic [15:0]      cnt_next;

  function automatic logic [WIDTH-1:0] act(
    input logic [1:0]       m,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] t
  );
    logic [WIDTH-1:0] r;
    r = x;
    unique case (1'b1)
      (m == 2'd0): r = (x <= t) ? '0 : x;
      (m == 2'd1): r = x[WIDTH-1] ? '0 : x;
      (m == 2'd2):
        if (x[WIDTH-1]) r = $signed(x) >>> LEAK_SHIFT;
      (m == 2'd3): begin
        // Negative upper bound leaves no valid non-negative range.
        if (x[WIDTH-1] || t[WIDTH-1]) r = '0;
        else if ($signed(x) > $signed(t)) r = t;
      end
    endcase
    return r;
  endfunction

  assign adv2     = !s2_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;
  assign accept   = in_valid && adv1;
  assign out_fire = s2_valid && out_ready;

  assign out_valid = s2_valid;
  assign out_data  = s2_data;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign act_data[g*WIDTH +: WIDTH] =
      act(s1_mode, s1_data[g*WIDTH +: WIDTH], s1_thr);
  end

  always_comb begin
    nz = '0;
    for (int i = 0; i < LANES; i++) begin
      if (s2_data[i*WIDTH +: WIDTH] == '0)
        nz = nz + 1'b1;
    end
  end

  assign cnt_sum  = {1'b0, zero_cnt} + {{(17-NZW){1'b0}}, nz};
  assign cnt_next = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mode  <= '0;
      s1_thr   <= '0;
    end else begin
      if (adv1)
        s1_valid <= in_valid;
      if (accept) begin
        s1_data <= in_data;
        s1_mode <= mode;
        s1_thr  <= threshold;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid)
        s2_data <= act_data;
    end
  end

  // Clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst)
      zero_cnt <= '0;
    else if (cnt_clr)
      zero_cnt <= '0;
    else if (out_fire)
      zero_cnt <= cnt_next;
  end

endmodule

// File: tb/tb_activation_unit.sv
// Directed self-checking bench for activation_unit.
// Immediate assertions at each check point; one summary line.
module tb_activation_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic [15:0] threshold;
  logic        cnt_clr;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [15:0] zero_cnt;

  int errors = 0;
  int checks = 0;

  activation_unit dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .threshold (threshold),
    .cnt_clr   (cnt_clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .zero_cnt  (zero_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Accept one beat, then look at S2 two cycles after acceptance.
  task automatic send_check(input string tag,
                            input logic [1:0] m,
                            input logic [15:0] t,
                            input logic [63:0] d,
                            input logic [63:0] exp);
    mode = m;
    threshold = t;
    in_data = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_lat1"}, {63'd0, out_valid}, 64'd0);
    tick();
    check({tag, "_v"}, {63'd0, out_valid}, 64'd1);
    check({tag, "_d"}, out_data, exp);
    tick();
  endtask

  int sent;
  int recv;
  int cyc;
  logic [63:0] prev_data;
  logic        prev_stall;
  logic [63:0] exp_beat;

  initial begin
    rst = 1'b1;
    mode = 2'd0;
    threshold = '0;
    cnt_clr = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_zero_cnt", {48'd0, zero_cnt}, 64'd0);
    rst = 1'b0;
    tick();
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);

    send_check("t1_m0", 2'd0, 16'h0100,
               64'h0000_8000_0101_0100,
               64'h0000_8000_0101_0000);
    check("t1_zcnt", {48'd0, zero_cnt}, 64'd2);

    send_check("t2_m2", 2'd2, 16'h0000,
               64'h8000_FFFF_0040_FF00,
               64'hF000_FFFF_0040_FFE0);
    check("t2_zcnt", {48'd0, zero_cnt}, 64'd2);
    send_check("t2_m1", 2'd1, 16'h0000,
               64'h8000_FFFF_0040_FF00,
               64'h0000_0000_0040_0000);
    check("t2b_zcnt", {48'd0, zero_cnt}, 64'd5);

    send_check("t3_m3", 2'd3, 16'h0200,
               64'h0200_FFF0_0100_0300,
               64'h0200_0000_0100_0200);
    send_check("t3_neg", 2'd3, 16'hFFFF,
               64'h0200_FFF0_0100_0300,
               64'h0000_0000_0000_0000);
    check("t3_zcnt", {48'd0, zero_cnt}, 64'd10);

    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_zcnt", {48'd0, zero_cnt}, 64'd0);

    // Test 5: back-to-back beats with different modes.
    mode = 2'd0;
    threshold = 16'h0100;
    in_data = 64'h0080_0080_0080_0080;
    in_valid = 1'b1;
    tick();
    mode = 2'd1;
    threshold = 16'h7FFF;
    tick();
    in_valid = 1'b0;
    check("t5_a_v", {63'd0, out_valid}, 64'd1);
    check("t5_a_d", out_data, 64'd0);
    tick();
    check("t5_b_v", {63'd0, out_valid}, 64'd1);
    check("t5_b_d", out_data, 64'h0080_0080_0080_0080);
    tick();
    check("t5_zcnt", {48'd0, zero_cnt}, 64'd4);
    check("t5_idle", {63'd0, out_valid}, 64'd0);

    // Test 4: 8 beats, stall downstream in cycles 3..6.
    sent = 0;
    recv = 0;
    cyc = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    mode = 2'd1;
    threshold = '0;
    while ((recv < 8) && (cyc < 40)) begin
      in_valid = (sent < 8);
      in_data = {16'(sent*256 + 4), 16'(sent*256 + 3),
                 16'(sent*256 + 2), 16'(sent*256 + 1)};
      out_ready = !((cyc >= 3) && (cyc <= 6));
      #1;
      if (prev_stall) begin
        check("t4_stall_v", {63'd0, out_valid}, 64'd1);
        check("t4_stall_d", out_data, prev_data);
      end
      if ((cyc >= 3) && (cyc <= 6))
        check("t4_in_ready_low", {63'd0, in_ready}, 64'd0);
      if (out_valid && out_ready) begin
        exp_beat = {16'(recv*256 + 4), 16'(recv*256 + 3),
                    16'(recv*256 + 2), 16'(recv*256 + 1)};
        check("t4_beat", out_data, exp_beat);
        recv++;
      end
      if (in_valid && in_ready)
        sent++;
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("t4_recv", 64'(recv), 64'd8);
    check("t4_sent", 64'(sent), 64'd8);
    tick();
    check("t4_no_dup", {63'd0, out_valid}, 64'd0);

    // Test 6: drive zero_cnt to FFFE, then saturate.
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    mode = 2'd1;
    in_data = '0;
    in_valid = 1'b1;
    repeat (16383) tick();
    in_data = 64'h0005_0005_0000_0000;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("t6_fffe", {48'd0, zero_cnt}, 64'hFFFE);
    in_data = '0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("t6_sat", {48'd0, zero_cnt}, 64'hFFFF);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("t6_sat_hold", {48'd0, zero_cnt}, 64'hFFFF);

    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("t6_clr_v", {63'd0, out_valid & out_ready}, 64'd1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("t6_clr_win", {48'd0, zero_cnt}, 64'd0);

    out_ready = 1'b0;
    in_data = 64'h0011_0022_0033_0044;
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    check("t6_inflight", {63'd0, out_valid}, 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    check("t6_rst_v", {63'd0, out_valid}, 64'd0);
    check("t6_rst_d", out_data, 64'd0);
    tick();
    check("t6_stale1", {63'd0, out_valid}, 64'd0);
    tick();
    check("t6_stale2", {63'd0, out_valid}, 64'd0);
    check("t6_rst_zcnt", {48'd0, zero_cnt}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
